// File: rtl/serial_bit_feeder.sv
// Parallel-to-serial feeder: accepts WIDTH-bit words on a valid/ready handshake and emits one bit per clk.
// Optional even-parity bit after each word when SERIAL_FEEDER_PARITY_EN is defined.
module serial_bit_feeder #(
  parameter int WIDTH      = 8,
  parameter int MSB_FIRST  = 1,
  parameter int GAP_CYCLES = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             bit_out,
  output logic             bit_valid,
  output logic             busy,
  output logic             word_done
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] PENULT_BIT = CNT_W'(WIDTH - 2);
  localparam logic [7:0] GAP_LAST = 8'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam bit NO_GAP = (GAP_CYCLES == 0);
  localparam bit MSB_SEL = (MSB_FIRST != 0);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SHIFT  = 2'd1;
  localparam logic [1:0] S_PARITY = 2'd2;
  localparam logic [1:0] S_GAP    = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [7:0]       gap_cnt_q, gap_cnt_d;
  logic             bit_out_q, bit_out_d;
  logic             bit_valid_q, bit_valid_d;
  logic             word_done_q, word_done_d;
  logic             final_cycle;
  logic             accept;
`ifdef SERIAL_FEEDER_PARITY_EN
  logic             parity_q, parity_d;
`endif

  // The last valid-bit cycle of a word is the only place a back-to-back accept can land.
`ifdef SERIAL_FEEDER_PARITY_EN
  assign final_cycle = (state_q == S_PARITY);
`else
  assign final_cycle = (state_q == S_SHIFT) && (bit_cnt_q == LAST_BIT);
`endif

  assign in_ready  = (state_q == S_IDLE) || (final_cycle && NO_GAP);
  assign busy      = (state_q != S_IDLE);
  assign accept    = in_valid && in_ready;
  assign bit_out   = bit_out_q;
  assign bit_valid = bit_valid_q;
  assign word_done = word_done_q;

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    bit_cnt_d   = bit_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    bit_out_d   = 1'b0;
    bit_valid_d = 1'b0;
    word_done_d = 1'b0;
`ifdef SERIAL_FEEDER_PARITY_EN
    parity_d    = parity_q;
`endif
    case (state_q)
      S_SHIFT: begin
        if (bit_cnt_q != LAST_BIT) begin
          bit_cnt_d   = bit_cnt_q + CNT_W'(1);
          bit_out_d   = MSB_SEL ? shift_q[WIDTH-1] : shift_q[0];
          shift_d     = MSB_SEL ? (shift_q << 1) : (shift_q >> 1);
          bit_valid_d = 1'b1;
`ifndef SERIAL_FEEDER_PARITY_EN
          word_done_d = (bit_cnt_q == PENULT_BIT);
`endif
        end else begin
`ifdef SERIAL_FEEDER_PARITY_EN
          state_d     = S_PARITY;
          bit_out_d   = parity_q;
          bit_valid_d = 1'b1;
          word_done_d = 1'b1;
`else
          state_d     = NO_GAP ? S_IDLE : S_GAP;
          gap_cnt_d   = 8'd0;
`endif
        end
      end
      S_PARITY: begin
        state_d   = NO_GAP ? S_IDLE : S_GAP;
        gap_cnt_d = 8'd0;
      end
      S_GAP: begin
        if (gap_cnt_q == GAP_LAST) state_d = S_IDLE;
        else gap_cnt_d = gap_cnt_q + 8'd1;
      end
      default: ;
    endcase
    // A new word overrides whatever the word-end path chose; the first bit is presented immediately.
    if (accept) begin
      state_d     = S_SHIFT;
      bit_cnt_d   = '0;
      bit_out_d   = MSB_SEL ? in_data[WIDTH-1] : in_data[0];
      shift_d     = MSB_SEL ? (in_data << 1) : (in_data >> 1);
      bit_valid_d = 1'b1;
      word_done_d = 1'b0;
`ifdef SERIAL_FEEDER_PARITY_EN
      parity_d    = ^in_data;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      gap_cnt_q   <= 8'd0;
      bit_out_q   <= 1'b0;
      bit_valid_q <= 1'b0;
      word_done_q <= 1'b0;
`ifdef SERIAL_FEEDER_PARITY_EN
      parity_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      bit_cnt_q   <= bit_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      bit_out_q   <= bit_out_d;
      bit_valid_q <= bit_valid_d;
      word_done_q <= word_done_d;
`ifdef SERIAL_FEEDER_PARITY_EN
      parity_q    <= parity_d;
`endif
    end
  end

endmodule

// File: tb/tb_serial_bit_feeder.sv
// Bench for serial_bit_feeder: two instances (MSB-first/no gap, LSB-first/gap 2) against a word-position model.
module tb_serial_bit_feeder;

  localparam int W = 8;
`ifdef SERIAL_FEEDER_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif

  logic         clk;
  logic         rst_n;
  logic [W-1:0] in_data;
  logic         in_valid;
  wire  [1:0]   rdy, bo, bv, bsy, wd;

  serial_bit_feeder #(.WIDTH(W), .MSB_FIRST(1), .GAP_CYCLES(0)) u_a (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(rdy[0]),
    .bit_out(bo[0]), .bit_valid(bv[0]), .busy(bsy[0]), .word_done(wd[0]));

  serial_bit_feeder #(.WIDTH(W), .MSB_FIRST(0), .GAP_CYCLES(2)) u_b (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(rdy[1]),
    .bit_out(bo[1]), .bit_valid(bv[1]), .busy(bsy[1]), .word_done(wd[1]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total_cnt = 0;
  int cyc = 0;

  // Model: a word occupies W data slots, PAR parity slots and GAP idle slots after its accept.
  logic         m_act [2];
  int           m_pos [2];
  logic [W-1:0] m_word[2];

  function automatic int gap_of(input int k);
    return (k == 0) ? 0 : 2;
  endfunction

  function automatic int len_of(input int k);
    return W + PAR + gap_of(k);
  endfunction

  function automatic logic m_rdy(input int k);
    return !m_act[k] || ((m_pos[k] == len_of(k) - 1) && (m_pos[k] < W + PAR));
  endfunction

  // {word_done, bit_valid, bit_out} for the current slot
  function automatic logic [2:0] m_slot(input int k);
    int p;
    logic b;
    p = m_pos[k];
    if (!m_act[k]) return 3'b000;
    if (p < W) begin
      b = (k == 0) ? m_word[k][W-1-p] : m_word[k][p];
      return {(p == W - 1) && (PAR == 0), 1'b1, b};
    end
    if (p < W + PAR) return {1'b1, 1'b1, ^m_word[k]};
    return 3'b000;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        m_act[k] = 1'b0;
        m_pos[k] = 0;
        m_word[k] = '0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        logic r;
        r = m_rdy(k);
        if (m_act[k]) begin
          m_pos[k] = m_pos[k] + 1;
          if (m_pos[k] == len_of(k)) m_act[k] = 1'b0;
        end
        if (in_valid && r) begin
          m_act[k] = 1'b1;
          m_pos[k] = 0;
          m_word[k] = in_data;
        end
      end
    end
  end

  logic [63:0] cap [2];
  int          cnt [2];
  int          wdc [2];
  int          gapc;

  always @(negedge clk) begin
    cyc++;
    for (int k = 0; k < 2; k++) begin
      logic [4:0] act, exp;
      act = {rdy[k], bsy[k], wd[k], bv[k], bo[k]};
      exp = {m_rdy(k), m_act[k], m_slot(k)};
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL cycle_check inst%0d cyc %0d got rdy/busy/done/vld/bit=%b want %b", k, cyc, act, exp);
      if (bv[k] === 1'b1) begin
        cap[k] = {cap[k][62:0], bo[k]};
        cnt[k]++;
      end
      if (wd[k] === 1'b1) wdc[k]++;
    end
    if (bsy[1] === 1'b1 && bv[1] === 1'b0) gapc++;
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    total_cnt++;
    if (got === want) pass_cnt++;
    else $display("FAIL %s got %0h want %0h", name, got, want);
  endtask

  task automatic clr();
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      cap[k] = '0;
      cnt[k] = 0;
      wdc[k] = 0;
    end
    gapc = 0;
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      cap[k] = '0;
      cnt[k] = 0;
      wdc[k] = 0;
    end
    gapc = 0;
    rst_n = 1'b0;
    in_valid = 1'b1;
    in_data = 8'hA5;

    // Reset held with in_valid high: nothing accepted
    repeat (3) @(negedge clk);
    check("reset_busy", 64'(bsy), 64'h0);
    check("reset_ready", 64'(rdy), 64'h3);
    check("reset_valid", 64'(bv), 64'h0);
    rst_n = 1'b1;

    // Single word A5 accepted at first edge after release
    @(negedge clk);
    check("first_bit_valid", 64'(bv), 64'h3);
    check("first_bit_value", 64'(bo), 64'h3);
    in_valid = 1'b0;
    repeat (14) @(negedge clk);
`ifndef SERIAL_FEEDER_PARITY_EN
    check("a5_msb_bits", cap[0], 64'hA5);
    check("a5_lsb_bits", cap[1], 64'hA5);
    check("a5_count", 64'(cnt[0]), 64'd8);
    check("a5_done_pulses", 64'(wdc[0]), 64'd1);

    // Back-to-back 0A, 05 with in_valid held
    clr();
    @(negedge clk);
    in_valid = 1'b1;
    in_data = 8'h0A;
    @(negedge clk);
    in_data = 8'h05;
    repeat (8) @(negedge clk);
    in_valid = 1'b0;
    repeat (20) @(negedge clk);
    check("b2b_msb_bits", cap[0], 64'h0A05);
    check("b2b_msb_count", 64'(cnt[0]), 64'd16);
    check("b2b_lsb_bits", cap[1], 64'h50);
    check("b2b_lsb_count", 64'(cnt[1]), 64'd8);

    // Words 01, 80: LSB-first instance inserts 2 gap cycles per word
    clr();
    @(negedge clk);
    in_valid = 1'b1;
    in_data = 8'h01;
    @(negedge clk);
    in_data = 8'h80;
    repeat (11) @(negedge clk);
    in_valid = 1'b0;
    repeat (25) @(negedge clk);
    check("gap_lsb_bits", cap[1], 64'h8001);
    check("gap_msb_bits", cap[0], 64'h0180);
    check("gap_cycles", 64'(gapc), 64'd4);
    check("gap_done_pulses", 64'(wdc[1]), 64'd2);

    // Reset after 3 bits of FF, then 0F restarts from bit 0
    clr();
    @(negedge clk);
    in_valid = 1'b1;
    in_data = 8'hFF;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midword_reset_valid", 64'(bv), 64'h0);
    check("midword_reset_bit", 64'(bo), 64'h0);
    check("midword_bits_before", 64'(cnt[0]), 64'd3);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    clr();
    @(negedge clk);
    in_valid = 1'b1;
    in_data = 8'h0F;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (15) @(negedge clk);
    check("restart_msb_bits", cap[0], 64'h0F);
    check("restart_lsb_bits", cap[1], 64'hF0);
    check("restart_count", 64'(cnt[0]), 64'd8);
`else
    check("a5_par_bits", cap[0], 64'h14A);
    check("a5_par_count", 64'(cnt[0]), 64'd9);
    check("a5_par_done", 64'(wdc[0]), 64'd1);
    clr();
    @(negedge clk);
    in_valid = 1'b1;
    in_data = 8'hA4;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (14) @(negedge clk);
    check("a4_par_bits", cap[0], 64'h149);
    check("a4_par_count", 64'(cnt[0]), 64'd9);
    check("a4_par_done", 64'(wdc[0]), 64'd1);
`endif

    // Randomized traffic with occasional asynchronous resets
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      in_valid = ($urandom_range(0, 3) != 0);
      in_data = 8'($urandom);
      if ($urandom_range(0, 199) == 0) begin
        @(posedge clk);
        #2 rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    repeat (20) @(negedge clk);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
